line_timing_driver: RTL

LINE_TIMING_DRIVER -- requirements
Module: line_timing_driver

---
 rtl/ltd_pkg.sv | 15 +
 rtl/ltd_pattern_gen.sv | 45 ++++
 rtl/line_timing_driver.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ltd_pkg.sv
// Shared types and constants for the line timing driver.
// Holds the FSM state encoding and the 24-bit test-pattern colours.
package ltd_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LINE = 1'b1
    } state_t;

    localparam logic [23:0] COLOR_LT = 24'hFFFFFF;
    localparam logic [23:0] COLOR_LB = 24'h00FF00;
    localparam logic [23:0] COLOR_RT = 24'h0000FF;
    localparam logic [23:0] COLOR_RB = 24'hFF0000;

endpackage

// File: rtl/ltd_pattern_gen.sv
// Quadrant test-pattern generator, used only when LTD_TEST_PATTERN_EN is set.
// Ports: hcnt/vcnt (raw timing counters) in; rgb (resized colour) out.
module ltd_pattern_gen
    import ltd_pkg::*;
#(
    parameter int CNT_W      = 14,
    parameter int DATA_WIDTH = 24,
    parameter int H_START    = 2,
    parameter int H_DISP     = 640,
    parameter int V_START    = 3,
    parameter int V_DISP     = 480
) (
    input  logic [CNT_W-1:0]      hcnt,
    input  logic [CNT_W-1:0]      vcnt,
    output logic [DATA_WIDTH-1:0] rgb
);

    localparam logic [CNT_W-1:0] H_MID = CNT_W'(H_START + H_DISP / 2);
    localparam logic [CNT_W-1:0] V_MID = CNT_W'(V_START + V_DISP / 2);

    logic        left;
    logic        top;
    logic [23:0] color;

    assign left = (hcnt < H_MID);
    assign top  = (vcnt < V_MID);

    always_comb begin
        color = COLOR_RB;
        case ({left, top})
            2'b11:   color = COLOR_LT;
            2'b10:   color = COLOR_LB;
            2'b01:   color = COLOR_RT;
            default: color = COLOR_RB;
        endcase
    end

    // Wider buses get zero-extended, narrower ones keep the MSBs.
    if (DATA_WIDTH >= 24) begin : g_ext
        assign rgb = DATA_WIDTH'(color);
    end else begin : g_trunc
        assign rgb = color[23 -: DATA_WIDTH];
    end

endmodule

// File: rtl/line_timing_driver.sv
// Line-triggered (or free-running) display timing generator with FIFO pixel path.
// Ports: clk, rst (sync, active-high), line_trig, data_in, fifo_empty, underflow_clr,
//   pattern_sel in; data_hs/vs/en/rgb, data_req, line_busy, frame_start,
//   underflow, trig_overrun out. Optional test pattern: define LTD_TEST_PATTERN_EN.
module line_timing_driver
    import ltd_pkg::*;
#(
    parameter int H_SYNC     = 1,
    parameter int H_BACK     = 1,
    parameter int H_DISP     = 640,
    parameter int H_FRONT    = 1,
    parameter int V_SYNC     = 1,
    parameter int V_BACK     = 2,
    parameter int V_DISP     = 480,
    parameter int V_FRONT    = 1,
    parameter int DATA_WIDTH = 24,
    parameter int CNT_W      = 14,
    parameter int H_AHEAD    = 1,
    parameter int FREE_RUN   = 0,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_trig,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_empty,
    input  logic                  underflow_clr,
    input  logic                  pattern_sel,
    output logic                  data_hs,
    output logic                  data_vs,
    output logic                  data_en,
    output logic [DATA_WIDTH-1:0] data_rgb,
    output logic                  data_req,
    output logic                  line_busy,
    output logic                  frame_start,
    output logic                  underflow,
    output logic                  trig_overrun
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT   = H_SYNC + H_BACK;
    localparam int V_ACT   = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] H_END_C  = CNT_W'(H_ACT + H_DISP);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] V_END_C  = CNT_W'(V_ACT + V_DISP);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_TOT_C  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] AHEAD_C  = CNT_W'(H_AHEAD);
    localparam logic [CNT_W:0]   H_TOT_X  = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0]   AHEAD_X  = (CNT_W+1)'(H_AHEAD);

    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    state_t                  state;
    logic [CNT_W-1:0]        hcnt;
    logic [CNT_W-1:0]        vcnt;
    logic                    pending;
    logic [DATA_WIDTH-1:0]   pix_q;
    logic [DATA_WIDTH-1:0]   pix_next;

    logic                    in_line;
    logic                    eol;
    logic                    go;
    logic                    ovr_set;
    logic [CNT_W-1:0]        vnext;
    logic [CNT_W:0]          ahead_sum;
    logic                    ahead_wrap;
    logic [CNT_W-1:0]        ahead_h;
    logic [CNT_W-1:0]        ahead_v;

    function automatic logic h_win(input logic [CNT_W-1:0] h);
        return (h >= H_ACT_C) && (h < H_END_C);
    endfunction

    function automatic logic v_win(input logic [CNT_W-1:0] v);
        return (v >= V_ACT_C) && (v < V_END_C);
    endfunction

    assign in_line = (state == ST_LINE);
    assign eol     = in_line && (hcnt == H_LAST);
    assign go      = (FREE_RUN != 0) || line_trig || pending;
    assign ovr_set = in_line && !eol && line_trig && pending;
    assign vnext   = (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);

    // The request position runs H_AHEAD clocks ahead; when that crosses
    // the end of the line it refers to pixel columns of the next line.
    assign ahead_sum  = {1'b0, hcnt} + AHEAD_X;
    assign ahead_wrap = (ahead_sum >= H_TOT_X);
    assign ahead_h    = ahead_wrap ? hcnt + AHEAD_C - H_TOT_C
                                   : hcnt + AHEAD_C;
    assign ahead_v    = ahead_wrap ? vnext : vcnt;

    assign line_busy = in_line;
    assign data_rgb  = data_en ? pix_q : '0;

`ifdef LTD_TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0] pat_rgb;

    ltd_pattern_gen #(
        .CNT_W      (CNT_W),
        .DATA_WIDTH (DATA_WIDTH),
        .H_START    (H_ACT),
        .H_DISP     (H_DISP),
        .V_START    (V_ACT),
        .V_DISP     (V_DISP)
    ) u_pattern (
        .hcnt (hcnt),
        .vcnt (vcnt),
        .rgb  (pat_rgb)
    );

    assign pix_next = pattern_sel ? pat_rgb : data_in;
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign pix_next           = data_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hcnt         <= '0;
            vcnt         <= '0;
            pending      <= 1'b0;
            data_hs      <= ~HS_ACT;
            data_vs      <= ~VS_ACT;
            data_en      <= 1'b0;
            data_req     <= 1'b0;
            frame_start  <= 1'b0;
            underflow    <= 1'b0;
            trig_overrun <= 1'b0;
            pix_q        <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    hcnt <= '0;
                    if (go) begin
                        state   <= ST_LINE;
                        pending <= 1'b0;
                    end
                end
                ST_LINE: begin
                    if (eol) begin
                        hcnt    <= '0;
                        vcnt    <= vnext;
                        // Pending is consumed by the next line; a trig on
                        // this same cycle then becomes the new pending one.
                        pending <= pending & line_trig;
                        if (!go) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        hcnt <= hcnt + CNT_W'(1);
                        if (line_trig) begin
                            pending <= 1'b1;
                        end
                    end
                end
            endcase

            data_hs     <= (hcnt < H_SYNC_C) ? HS_ACT : ~HS_ACT;
            data_vs     <= (vcnt < V_SYNC_C) ? VS_ACT : ~VS_ACT;
            data_en     <= in_line && h_win(hcnt) && v_win(vcnt);
            data_req    <= in_line && h_win(ahead_h) && v_win(ahead_v);
            frame_start <= in_line && (hcnt == '0) && (vcnt == '0);
            pix_q       <= pix_next;

            // A new event in the clearing cycle keeps the flag set.
            underflow    <= (underflow & ~underflow_clr)
                          | (data_req & fifo_empty);
            trig_overrun <= (trig_overrun & ~underflow_clr) | ovr_set;
        end
    end

endmodule
